// File: rtl/cpu_uart_transmitter.sv
// Buffered 8N1 UART transmitter for the CPU peripheral bus.
// Bytes are queued in a small FIFO and shifted out LSB-first, one bit per BAUD_DIV clocks.
module cpu_uart_transmitter #(
  parameter int unsigned BAUD_DIV   = 5208,
  parameter int unsigned FIFO_DEPTH = 4
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       TX_EN,
  input  logic [7:0] TX_DATA,
  output logic       UART_TX,
  output logic       TX_READY,
  output logic       TX_BUSY,
  output logic       TX_DONE,
  output logic       TX_OVF
);

  localparam int unsigned DATA_W = 8;
  localparam int unsigned CNT_W  = 16;
  localparam int unsigned BIT_W  = 3;
  localparam int unsigned PTR_W  = $clog2(FIFO_DEPTH);
  localparam int unsigned OCC_W  = PTR_W + 1;

  localparam logic [CNT_W-1:0] BAUD_LAST = CNT_W'(BAUD_DIV - 1);
  localparam logic [OCC_W-1:0] OCC_FULL  = OCC_W'(FIFO_DEPTH);
  localparam logic [BIT_W-1:0] LAST_BIT  = BIT_W'(DATA_W - 1);

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_START,
    ST_DATA,
    ST_STOP
  } state_t;

  state_t             state_q, state_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic [BIT_W-1:0]   bit_q, bit_d;
  logic [DATA_W-1:0]  shift_q, shift_d;
  logic [PTR_W-1:0]   wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0]   rd_ptr_q, rd_ptr_d;
  logic [OCC_W-1:0]   occ_q, occ_d;
  logic [DATA_W-1:0]  mem [FIFO_DEPTH];

  logic tx_q, tx_d;
  logic ready_q, ready_d;
  logic busy_q, busy_d;
  logic done_q, done_d;
  logic ovf_q, ovf_d;

  logic bit_end;
  logic fifo_empty;
  logic fifo_full;
  logic push;
  logic pop;

  assign bit_end    = (cnt_q == BAUD_LAST);
  assign fifo_empty = (occ_q == '0);
  assign fifo_full  = (occ_q == OCC_FULL);
  // Fullness is judged before the edge, so a same-edge pop never frees room.
  assign push       = TX_EN && !fifo_full;

  // Frame sequencer: next state, baud counter, bit index and shift register
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    bit_d   = bit_q;
    shift_d = shift_q;
    pop     = 1'b0;
    done_d  = 1'b0;
    unique case (state_q)
      ST_IDLE: begin
        if (!fifo_empty) begin
          pop     = 1'b1;
          shift_d = mem[rd_ptr_q];
          cnt_d   = '0;
          state_d = ST_START;
        end
      end
      ST_START: begin
        if (bit_end) begin
          cnt_d   = '0;
          bit_d   = '0;
          state_d = ST_DATA;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      ST_DATA: begin
        if (bit_end) begin
          cnt_d   = '0;
          shift_d = {1'b0, shift_q[DATA_W-1:1]};
          bit_d   = bit_q + BIT_W'(1);
          if (bit_q == LAST_BIT) begin
            state_d = ST_STOP;
          end
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      ST_STOP: begin
        if (bit_end) begin
          cnt_d  = '0;
          done_d = 1'b1;
          // Chain straight into the next start bit when more data is queued
          if (!fifo_empty) begin
            pop     = 1'b1;
            shift_d = mem[rd_ptr_q];
            state_d = ST_START;
          end else begin
            state_d = ST_IDLE;
          end
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  // FIFO bookkeeping and registered status/line values
  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    tx_d     = 1'b1;
    if (push) begin
      wr_ptr_d = wr_ptr_q + PTR_W'(1);
    end
    if (pop) begin
      rd_ptr_d = rd_ptr_q + PTR_W'(1);
    end
    occ_d   = occ_q + OCC_W'(push) - OCC_W'(pop);
    ready_d = (occ_d != OCC_FULL);
    busy_d  = (state_d != ST_IDLE) || (occ_d != '0);
    ovf_d   = ovf_q || (TX_EN && fifo_full);
    unique case (state_d)
      ST_IDLE:  tx_d = 1'b1;
      ST_START: tx_d = 1'b0;
      ST_DATA:  tx_d = shift_d[0];
      ST_STOP:  tx_d = 1'b1;
      default:  tx_d = 1'b1;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q  <= ST_IDLE;
      cnt_q    <= '0;
      bit_q    <= '0;
      shift_q  <= '0;
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      occ_q    <= '0;
      tx_q     <= 1'b1;
      ready_q  <= 1'b1;
      busy_q   <= 1'b0;
      done_q   <= 1'b0;
      ovf_q    <= 1'b0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      bit_q    <= bit_d;
      shift_q  <= shift_d;
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      occ_q    <= occ_d;
      tx_q     <= tx_d;
      ready_q  <= ready_d;
      busy_q   <= busy_d;
      done_q   <= done_d;
      ovf_q    <= ovf_d;
    end
  end

  // Storage needs no reset; validity is tracked by the pointers and occupancy
  always_ff @(posedge clk) begin
    if (push) begin
      mem[wr_ptr_q] <= TX_DATA;
    end
  end

  assign UART_TX  = tx_q;
  assign TX_READY = ready_q;
  assign TX_BUSY  = busy_q;
  assign TX_DONE  = done_q;
  assign TX_OVF   = ovf_q;

endmodule

// File: tb/tb_cpu_uart_transmitter.sv
// Bench for cpu_uart_transmitter: timeline model of queued frames checked every cycle,
// plus a line decoder and hand-computed directed expectations.
module tb_cpu_uart_transmitter;

  localparam int unsigned B = 16;
  localparam int unsigned D = 4;

  logic       clk = 1'b0;
  logic       reset;
  logic       tx_en, tx_en2;
  logic [7:0] tx_data, tx_data2;
  logic       uart_tx, tx_ready, tx_busy, tx_done, tx_ovf;
  logic       uart_tx2, tx_ready2, tx_busy2, tx_done2, tx_ovf2;

  int checks = 0;
  int failures = 0;

  always #5 clk = ~clk;

  cpu_uart_transmitter #(.BAUD_DIV(B), .FIFO_DEPTH(D)) dut (
    .clk(clk), .reset(reset), .TX_EN(tx_en), .TX_DATA(tx_data),
    .UART_TX(uart_tx), .TX_READY(tx_ready), .TX_BUSY(tx_busy),
    .TX_DONE(tx_done), .TX_OVF(tx_ovf)
  );

  cpu_uart_transmitter #(.BAUD_DIV(2), .FIFO_DEPTH(D)) dut_min (
    .clk(clk), .reset(reset), .TX_EN(tx_en2), .TX_DATA(tx_data2),
    .UART_TX(uart_tx2), .TX_READY(tx_ready2), .TX_BUSY(tx_busy2),
    .TX_DONE(tx_done2), .TX_OVF(tx_ovf2)
  );

  task automatic chk1(input string name, input logic act, input logic exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%b required=%b at %0t", name, act, exp, $time);
    end
  endtask

  task automatic chkv(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      failures++;
      $display("FAIL %s actual=%0d required=%0d at %0t", name, act, exp, $time);
    end
  endtask

  // Model: FIFO as a queue; an active frame is a start edge plus a byte, and the
  // line level follows from elapsed edges divided by the bit period.
  logic [7:0] mq[$];
  logic [7:0] m_cur = 8'h00;
  bit         m_act = 1'b0;
  bit         m_ovf = 1'b0;
  bit         m_done = 1'b0;
  longint     m_e = 0;
  longint     m_s = 0;
  longint     done_q[$];

  initial begin
    int n;
    bit ending;
    forever begin
      @(posedge clk or posedge reset);
      if (reset) begin
        mq.delete();
        m_act  = 1'b0;
        m_ovf  = 1'b0;
        m_done = 1'b0;
      end else begin
        m_e++;
        n = mq.size();
        ending = m_act && ((m_e - m_s) == longint'(10 * B));
        m_done = ending;
        if (ending) done_q.push_back(m_e);
        if (tx_en && n == int'(D)) m_ovf = 1'b1;
        if ((!m_act || ending) && n > 0) begin
          m_cur = mq.pop_front();
          m_act = 1'b1;
          m_s   = m_e;
        end else if (ending) begin
          m_act = 1'b0;
        end
        if (tx_en && n < int'(D)) mq.push_back(tx_data);
      end
    end
  end

  function automatic logic exp_line();
    int bitn;
    if (!m_act) return 1'b1;
    bitn = int'(m_e - m_s) / int'(B);
    if (bitn == 0) return 1'b0;
    if (bitn <= 8) return m_cur[bitn-1];
    return 1'b1;
  endfunction

  initial begin
    forever begin
      @(negedge clk);
      chk1("uart_tx", uart_tx, exp_line());
      chk1("tx_ready", tx_ready, mq.size() != int'(D));
      chk1("tx_busy", tx_busy, m_act || (mq.size() != 0));
      chk1("tx_done", tx_done, m_done);
      chk1("tx_ovf", tx_ovf, m_ovf);
    end
  end

  // Line decoder: detect start bit, sample each bit at its middle
  logic [7:0] rxq[$];
  initial begin
    logic       prev;
    logic [7:0] b;
    prev = 1'b1;
    b = 8'h00;
    forever begin
      @(negedge clk);
      if (prev && !uart_tx && !reset) begin
        repeat (B / 2) @(negedge clk);
        for (int i = 0; i < 8; i++) begin
          repeat (B) @(negedge clk);
          b[i] = uart_tx;
        end
        repeat (B) @(negedge clk);
        rxq.push_back(b);
        prev = uart_tx;
      end else begin
        prev = uart_tx;
      end
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic wr(input logic [7:0] d);
    tx_en   = 1'b1;
    tx_data = d;
    step();
    tx_en   = 1'b0;
  endtask

  task automatic wait_idle(input int limit, input string name);
    int n = 0;
    while (tx_busy && n < limit) begin
      step();
      n++;
    end
    chk1(name, tx_busy, 1'b0);
  endtask

  initial begin
    #400000;
    $display("FAIL watchdog expired at %0t", $time);
    $fatal(1, "watchdog");
  end

  initial begin
    logic [9:0]  lv;
    logic [19:0] e2;
    logic [7:0]  exp_b2b [3];
    int          lows;

    reset = 1'b1; tx_en = 1'b0; tx_data = 8'h00; tx_en2 = 1'b0; tx_data2 = 8'h00;
    repeat (3) @(posedge clk);
    #1;
    chk1("rst_uart_tx", uart_tx, 1'b1);
    chk1("rst_ready", tx_ready, 1'b1);
    chk1("rst_busy", tx_busy, 1'b0);
    chk1("rst_done", tx_done, 1'b0);
    chk1("rst_ovf", tx_ovf, 1'b0);
    reset = 1'b0;
    step(); step();

    // Single byte 0x55
    wr(8'h55);
    chk1("sb_idle_on_push", uart_tx, 1'b1);
    chk1("sb_busy_on_push", tx_busy, 1'b1);
    step();
    chk1("sb_start_low", uart_tx, 1'b0);
    lv = 10'b1010101010;
    for (int i = 1; i < 10; i++) begin
      repeat (B) step();
      chk1($sformatf("sb_level%0d", i), uart_tx, lv[i]);
    end
    repeat (B) step();
    chk1("sb_done", tx_done, 1'b1);
    chk1("sb_busy_fall", tx_busy, 1'b0);
    chk1("sb_line_idle", uart_tx, 1'b1);
    step();
    chk1("sb_done_once", tx_done, 1'b0);

    // Back-to-back 0x00, 0xFF, 0xA3
    rxq.delete();
    done_q.delete();
    wr(8'h00); wr(8'hFF); wr(8'hA3);
    wait_idle(600, "b2b_drain");
    repeat (4) step();
    exp_b2b[0] = 8'h00; exp_b2b[1] = 8'hFF; exp_b2b[2] = 8'hA3;
    chkv("b2b_frames", rxq.size(), 3);
    if (rxq.size() == 3) begin
      for (int i = 0; i < 3; i++) chkv($sformatf("b2b_byte%0d", i), int'(rxq[i]), int'(exp_b2b[i]));
    end
    chkv("b2b_done_count", done_q.size(), 3);
    if (done_q.size() == 3) begin
      chkv("b2b_done_gap1", int'(done_q[1] - done_q[0]), 160);
      chkv("b2b_done_gap2", int'(done_q[2] - done_q[1]), 160);
    end

    // Overflow: six writes, first popped on the second edge
    rxq.delete();
    wr(8'h10); wr(8'h11); wr(8'h12); wr(8'h13);
    chk1("ovf_ready_after4", tx_ready, 1'b1);
    wr(8'h14);
    chk1("ovf_ready_after5", tx_ready, 1'b0);
    chk1("ovf_flag_after5", tx_ovf, 1'b0);
    wr(8'h15);
    chk1("ovf_flag_after6", tx_ovf, 1'b1);
    chk1("ovf_ready_after6", tx_ready, 1'b0);
    wait_idle(1000, "ovf_drain");
    repeat (4) step();
    chkv("ovf_frames", rxq.size(), 5);
    if (rxq.size() == 5) begin
      for (int i = 0; i < 5; i++) chkv($sformatf("ovf_byte%0d", i), int'(rxq[i]), 16 + i);
    end
    chk1("ovf_sticky", tx_ovf, 1'b1);

    // Full FIFO, write lands on the edge a stop bit completes
    reset = 1'b1; step(); step(); reset = 1'b0; step();
    chk1("full_ovf_cleared", tx_ovf, 1'b0);
    wr(8'h20); wr(8'h21); wr(8'h22); wr(8'h23); wr(8'h24);
    chk1("full_ready_low", tx_ready, 1'b0);
    repeat (156) step();
    chk1("full_pre_ovf", tx_ovf, 1'b0);
    chk1("full_pre_ready", tx_ready, 1'b0);
    tx_en = 1'b1; tx_data = 8'h99; step(); tx_en = 1'b0;
    chk1("full_done", tx_done, 1'b1);
    chk1("full_drop_ovf", tx_ovf, 1'b1);
    chk1("full_ready_after_pop", tx_ready, 1'b1);
    wait_idle(1000, "full_drain");

    // Reset during data bit 3 of 0xF7 with two bytes queued
    wr(8'hF7); wr(8'h33); wr(8'h44);
    repeat (68) step();
    chk1("mid_bit3_low", uart_tx, 1'b0);
    chk1("mid_ovf_set", tx_ovf, 1'b1);
    #2 reset = 1'b1;
    #1;
    chk1("mid_async_tx", uart_tx, 1'b1);
    chk1("mid_async_busy", tx_busy, 1'b0);
    chk1("mid_async_ready", tx_ready, 1'b1);
    chk1("mid_async_done", tx_done, 1'b0);
    chk1("mid_async_ovf", tx_ovf, 1'b0);
    step(); step();
    reset = 1'b0;
    lows = 0;
    repeat (400) begin
      step();
      if (!uart_tx) lows++;
    end
    chkv("post_reset_no_frames", lows, 0);
    chk1("post_reset_idle", tx_busy, 1'b0);

    // Minimum divider, 0x81
    tx_en2 = 1'b1; tx_data2 = 8'h81; step(); tx_en2 = 1'b0;
    chk1("min_idle_on_push", uart_tx2, 1'b1);
    e2 = 20'hF000C;
    for (int j = 0; j < 20; j++) begin
      step();
      chk1($sformatf("min_cycle%0d", j), uart_tx2, e2[j]);
    end
    step();
    chk1("min_done", tx_done2, 1'b1);
    chk1("min_line_idle", uart_tx2, 1'b1);
    chk1("min_busy_fall", tx_busy2, 1'b0);
    chk1("min_ready", tx_ready2, 1'b1);
    chk1("min_ovf", tx_ovf2, 1'b0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/cpu_uart_transmitter.md
# cpu_uart_transmitter

UART transmit side of the single-cycle CPU's serial peripheral, pairing with the UART receiver on the same board link. It accepts bytes from the CPU's peripheral bus through a one-cycle write strobe and buffers them in a small FIFO. Each byte is sent as an 8N1 frame (1 start, 8 data LSB-first, 1 stop) on UART_TX. Baud timing comes from an internal divider on the single system clock, so no separate sample clock is needed.

## Interface
- BAUD_DIV, 5208: system clock cycles per bit (50 MHz / 9600 baud); legal range 2..65535.
- FIFO_DEPTH, 4: FIFO entries; power of two, 2..16.
- clk  input  1  system clock; all logic on the rising edge.
- reset  input  1  asynchronous, active-high reset.
- TX_EN  input  1  write strobe; one byte per cycle sampled high.
- TX_DATA  input  8  byte to send; sampled with TX_EN.
- UART_TX  output  1  serial line; idles high.
- TX_READY  output  1  FIFO not full; a write this cycle is accepted.
- TX_BUSY  output  1  frame in progress or FIFO non-empty.
- TX_DONE  output  1  one-cycle pulse at the end of each stop bit.
- TX_OVF  output  1  sticky; set when a write is dropped, cleared only by reset.

## Operation
- **Reset values.** UART_TX=1, TX_READY=1, TX_BUSY=0, TX_DONE=0, TX_OVF=0. FIFO is emptied, state=IDLE, baud counter=0, bit index=0.
- **FIFO write.**
  - Accepted iff TX_EN=1 and occupancy<FIFO_DEPTH, judged on the registered occupancy before the edge.
  - A pop on the same edge does not make room for a write when full.
  - A write that is not accepted sets TX_OVF; the FIFO is unchanged.
- **FIFO ordering and width.**
  - Push and pop on the same edge leave occupancy unchanged; data stays strictly FIFO ordered.
  - Read and write pointers wrap modulo FIFO_DEPTH.
  - Occupancy register is log2(FIFO_DEPTH)+1 bits wide.
- **Status outputs.**
  - TX_READY = (occupancy != FIFO_DEPTH), decoded from registers.
  - TX_BUSY = (state != IDLE) || (occupancy != 0).
- **IDLE.** UART_TX=1. If the FIFO is non-empty: pop the head into the shift register, clear the baud counter, go to START. There is no bypass; a byte written while empty is popped on the following edge.
- **START.** UART_TX=0 for BAUD_DIV cycles, then go to DATA with bit index 0.
- **DATA.**
  - UART_TX = shift[0]; each bit lasts BAUD_DIV cycles.
  - At each bit end: shift right, increment bit index.
  - After bit 7, go to STOP.
- **STOP.** UART_TX=1 for BAUD_DIV cycles.
  - At the last cycle's edge: TX_DONE=1 for the next cycle.
  - If the FIFO is non-empty, pop and go straight to START (back-to-back, no idle gap); otherwise go to IDLE.
- **Baud counter.** Counts 0..BAUD_DIV-1, 16 bits wide. Bit end is the edge where counter==BAUD_DIV-1; the counter returns to 0 there.
- **Reset mid-frame.** The frame is abandoned; UART_TX goes high asynchronously; the FIFO is flushed.
- **Data patterns.** 0x00 and 0xFF need no special handling. The start/stop framing guarantees edges.

## Timing
- TX_EN sampled at edge k with the FIFO empty and state IDLE:
  - edge k: FIFO push;
  - edge k+1: pop, and UART_TX low from just after edge k+1.
- Start-bit latency from the accepting edge: 1 clock.
- Frame length: exactly 10×BAUD_DIV clocks, from the start-bit falling edge to the end of the stop bit.
- Back-to-back frames: N queued bytes take N×10×BAUD_DIV clocks with no extra cycles.
- TX_DONE is asserted during the first cycle after the last stop-bit cycle. That is the same cycle the next start bit begins, if one is queued.
- TX_READY and TX_OVF update on the edge after the causing write.

## Test plan
- **Single byte.**
  - Stimulus: BAUD_DIV=16, write 0x55 when idle.
  - UART_TX: low starting 1 clock after the write edge, then 1,0,1,0,1,0,1,0, then high. Each level holds 16 clocks.
  - One TX_DONE pulse 160 clocks after the start-bit edge; TX_BUSY falls the same cycle.
- **Back-to-back.**
  - Stimulus: BAUD_DIV=16, write 0x00, 0xFF, 0xA3 on consecutive cycles.
  - Three contiguous frames totalling 480 clocks with no idle gap; three TX_DONE pulses, 160 clocks apart.
  - Decoded bytes match, in order.
- **Overflow.**
  - Stimulus: FIFO_DEPTH=4, six writes on consecutive cycles starting idle.
  - The first five are accepted (one popped at the second edge). TX_READY=0 after the fifth write; the sixth is dropped and TX_OVF=1.
  - Exactly five frames are sent; TX_OVF stays 1 afterwards.
- **Simultaneous push/pop when full.**
  - Stimulus: FIFO full; write on the exact edge a STOP completes.
  - The write is dropped and TX_OVF=1. Occupancy goes from 4 to 3.
- **Reset mid-frame.**
  - Stimulus: assert reset during DATA bit 3 with 2 bytes queued.
  - UART_TX=1 immediately without waiting for a clock edge; all outputs at reset values.
  - After release, no further frames are sent.
- **Minimum divider.**
  - Stimulus: BAUD_DIV=2, write 0x81.
  - Frame is 20 clocks: start 2, bits 1,0,0,0,0,0,0,1 at 2 clocks each, stop 2.
